// File: rtl/tinker_pkg.sv
// Shared Tinker core types, constants and instruction field positions.
package tinker_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam addr_t TINKER_RESET_PC = 64'h2000;
    localparam int    INSTR_BYTES     = 4;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 27;
    localparam int RD_MSB      = 26;
    localparam int RD_LSB      = 22;
    localparam int RS_MSB      = 21;
    localparam int RS_LSB      = 17;
    localparam int RT_MSB      = 16;
    localparam int RT_LSB      = 12;
    localparam int LITERAL_MSB = 11;
    localparam int LITERAL_LSB = 0;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_HALTED,
        FETCH_DRAIN
    } fetch_state_e;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    function automatic logic [4:0] instr_opcode(input instr_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/tinker_prefetch_fifo.sv
// Generic synchronous FIFO; head is registered storage, so write-to-read latency is 1 cycle.
// No internal backpressure: the owner must never push into a full FIFO unless it pops in the same cycle.
module tinker_prefetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/tinker_prefetch_queue.sv
// In-order instruction prefetch ahead of the decoder; rsp->dec_valid is 1 cycle (0 with TINKER_PREFETCH_BYPASS_EN).
// Requests are credit-limited so buffered plus in-flight words never exceed DEPTH; the decoder stalls via dec_ready.
module tinker_prefetch_queue
    import tinker_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = TINKER_RESET_PC
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   halt,
    output logic   mem_req_valid,
    input  logic   mem_req_ready,
    output addr_t  mem_req_addr,
    input  logic   mem_rsp_valid,
    input  instr_t mem_rsp_data,
    output logic   dec_valid,
    input  logic   dec_ready,
    output instr_t dec_instr,
    output addr_t  dec_pc,
    input  logic   redirect,
    input  addr_t  redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    addr_t         fetch_pc;
    addr_t         rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_nxt;
    logic          req_hs;
    logic          dropping;
    logic          bypass;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign mem_req_valid = !reset && !halt && !redirect &&
                           ((SW'(occupancy) + SW'(outstanding)) < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_hs        = mem_req_valid && mem_req_ready;

    // A response landing in the redirect cycle is stale and already retired, so it is not counted.
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (redirect) begin
            drop_cnt_nxt = outstanding - CW'(mem_rsp_valid);
        end else if (mem_rsp_valid && dropping) begin
            drop_cnt_nxt = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = halt ? FETCH_HALTED : FETCH_RUN;
        if (drop_cnt_nxt != '0) begin
            state_nxt = FETCH_DRAIN;
        end
    end

    always_comb begin
        dropping = (state == FETCH_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_cnt_nxt;
            if (redirect) begin
                fetch_pc <= {redirect_pc[63:2], 2'b00};
            end else if (req_hs) begin
                fetch_pc <= fetch_pc + addr_t'(INSTR_BYTES);
            end
        end
    end

`ifdef TINKER_PREFETCH_BYPASS_EN
    assign bypass = fifo_empty && !dropping && mem_rsp_valid && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_empty = (occupancy == '0);
    assign dec_valid  = !fifo_empty || bypass;
    assign fifo_push  = mem_rsp_valid && !dropping && !redirect && !(bypass && dec_ready);
    assign fifo_pop   = !fifo_empty && dec_ready;
    assign push_entry = '{pc: rsp_pc, instr: mem_rsp_data};

    always_comb begin
        dec_pc    = '0;
        dec_instr = '0;
        if (!fifo_empty) begin
            dec_pc    = head.pc;
            dec_instr = head.instr;
        end else if (bypass) begin
            dec_pc    = rsp_pc;
            dec_instr = mem_rsp_data;
        end
    end

    tinker_prefetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (occupancy)
    );

    // Holds the PC of every fetch still in flight, so its count is the outstanding-fetch count.
    tinker_prefetch_fifo #(
        .WIDTH ($bits(addr_t)),
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_hs),
        .push_data (fetch_pc),
        .pop       (mem_rsp_valid),
        .head      (rsp_pc),
        .count     (outstanding)
    );

endmodule

// File: tb/tb_tinker_prefetch_queue.sv
// Self-checking bench for tinker_prefetch_queue: directed vectors plus a randomized run against a queue-level model.
module tb_tinker_prefetch_queue;
    import tinker_pkg::*;

    localparam int DEPTH = 4;

    logic   clk = 1'b0;
    logic   reset;
    logic   halt;
    logic   mem_req_valid;
    logic   mem_req_ready;
    addr_t  mem_req_addr;
    logic   mem_rsp_valid;
    instr_t mem_rsp_data;
    logic   dec_valid;
    logic   dec_ready;
    instr_t dec_instr;
    addr_t  dec_pc;
    logic   redirect;
    addr_t  redirect_pc;

    always #5 clk = ~clk;

    tinker_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h2000)) dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    typedef struct { addr_t addr; longint unsigned due; int epoch; } pend_t;
    typedef struct { addr_t pc; bit done; } exp_t;
    typedef struct {
        logic   req_rdy;
        logic   dec_rdy;
        logic   rv;
        addr_t  addr;
        logic   dv;
        addr_t  pc;
        instr_t instr;
    } vec_t;

    pend_t            pend[$];
    exp_t             expq[$];
    addr_t            model_pc;
    int               epoch;
    int               lat;
    longint unsigned  cyc;
    longint unsigned  last_due;
    int               n_cmp;
    int               n_err;
    logic             obs_rv;
    logic             obs_dv;
    logic             obs_req_hs;
    logic             obs_dec_hs;
    addr_t            obs_addr;
    addr_t            obs_pc;
    instr_t           obs_instr;

    function automatic instr_t mem_word(input addr_t a);
        if (a == 64'h2000) return 32'hC800_0000;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive the memory response, check outputs at the falling edge, advance the model.
    task automatic step();
        bit              rsp_now;
        bit              rsp_cur;
        bit              exp_dv;
        bit              exp_rv;
        int              occ;
        pend_t           rsp_ent;
        longint unsigned d;

        rsp_now = 0;
        rsp_ent = '{addr: '0, due: 0, epoch: -1};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_now       = 1;
            rsp_ent       = pend[0];
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        rsp_cur = rsp_now && (rsp_ent.epoch == epoch);

        @(negedge clk);
        occ = 0;
        foreach (expq[i]) if (expq[i].done) occ++;
        exp_rv = !halt && !redirect && ((occ + pend.size()) < DEPTH);
        exp_dv = (expq.size() > 0) && expq[0].done;
`ifdef TINKER_PREFETCH_BYPASS_EN
        if (!exp_dv && rsp_cur && !redirect) exp_dv = 1;
`endif
        obs_rv     = mem_req_valid;
        obs_addr   = mem_req_addr;
        obs_dv     = dec_valid;
        obs_pc     = dec_pc;
        obs_instr  = dec_instr;
        obs_req_hs = mem_req_valid && mem_req_ready;
        obs_dec_hs = dec_valid && dec_ready;

        chk("req_valid", mem_req_valid, exp_rv);
        chk("req_addr", mem_req_addr, model_pc);
        chk("dec_valid", dec_valid, exp_dv);
        if (exp_dv) begin
            chk("dec_pc", dec_pc, expq[0].pc);
            chk("dec_instr", dec_instr, mem_word(expq[0].pc));
        end

        if (rsp_now) begin
            void'(pend.pop_front());
            if (rsp_cur) begin
                for (int i = 0; i < expq.size(); i++) begin
                    if (!expq[i].done) begin
                        expq[i].done = 1;
                        break;
                    end
                end
            end
        end
        if (exp_dv && dec_ready) void'(expq.pop_front());
        if (obs_req_hs) begin
            d = cyc + longint'(lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: mem_req_addr, due: d, epoch: epoch});
            expq.push_back('{pc: model_pc, done: 1'b0});
            model_pc = model_pc + 64'd4;
        end
        if (redirect) begin
            expq.delete();
            epoch++;
            model_pc = {redirect_pc[63:2], 2'b00};
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 64'h2000);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 64'h0);
        pend.delete();
        expq.delete();
        epoch++;
        model_pc      = 64'h2000;
        last_due      = cyc;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        halt          = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t  tbl[5];
        int    n_req;
        int    n_dec;
        bit    seen;
        addr_t addrs[2];

        n_cmp = 0; n_err = 0; epoch = 0; cyc = 0; last_due = 0; lat = 1;
        mem_req_ready = 1'b1; dec_ready = 1'b1;

        // Latency-1 memory, decoder always ready: steady one-per-cycle flow.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0,    32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 64'h2004, 1'b0, 64'h0,    32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 64'h2008, 1'b1, 64'h2000, 32'hC800_0000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h200C, 1'b1, 64'h2004, mem_word(64'h2004)};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 64'h2010, 1'b1, 64'h2008, mem_word(64'h2008)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = tbl[i].req_rdy;
            dec_ready     = tbl[i].dec_rdy;
            step();
            chk("tbl_req_valid", obs_rv, tbl[i].rv);
            chk("tbl_req_addr", obs_addr, tbl[i].addr);
            chk("tbl_dec_valid", obs_dv, tbl[i].dv);
            if (tbl[i].dv) begin
                chk("tbl_dec_pc", obs_pc, tbl[i].pc);
                chk("tbl_dec_instr", obs_instr, tbl[i].instr);
            end
        end

        // Stalled decoder: credits cap issue at DEPTH, then draining resumes at 0x2010.
        do_reset();
        lat = 1; dec_ready = 1'b0; n_req = 0;
        repeat (10) begin step(); if (obs_req_hs) n_req++; end
        chk("fill_req_count", n_req, 4);
        dec_ready = 1'b1; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (obs_req_hs) begin seen = 1; chk("resume_addr", obs_addr, 64'h2010); end
        end
        chk("resume_seen", seen, 1'b1);

        // Redirect with two stale fetches in flight.
        do_reset();
        lat = 3; dec_ready = 1'b1;
        step(); step();
        redirect = 1'b1; redirect_pc = 64'h3003;
        step();
        redirect = 1'b0;
        chk("redir_no_req", obs_req_hs, 1'b0);
        step();
        chk("redir_req_hs", obs_req_hs, 1'b1);
        chk("redir_req_addr", obs_addr, 64'h3000);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (obs_dec_hs) begin seen = 1; chk("redir_first_pc", obs_pc, 64'h3000); end
        end
        chk("redir_dec_seen", seen, 1'b1);

        // Halt with two outstanding: no issue, both words still delivered.
        do_reset();
        lat = 3; dec_ready = 1'b1;
        step(); step();
        halt = 1'b1; n_req = 0; n_dec = 0;
        repeat (8) begin step(); if (obs_req_hs) n_req++; if (obs_dec_hs) n_dec++; end
        chk("halt_req_count", n_req, 0);
        chk("halt_dec_count", n_dec, 2);
        halt = 1'b0;
        step();
        chk("unhalt_req_hs", obs_req_hs, 1'b1);
        chk("unhalt_req_addr", obs_addr, 64'h2008);

        // Fetch PC wraps from the top of the address space to zero.
        lat = 1;
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0; n_req = 0;
        for (int i = 0; i < 20 && n_req < 2; i++) begin
            step();
            if (obs_req_hs) begin addrs[n_req] = obs_addr; n_req++; end
        end
        chk("wrap_req_count", n_req, 2);
        if (n_req == 2) begin
            chk("wrap_addr0", addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_addr1", addrs[1], 64'h0);
        end

        // Asynchronous reset with the queue half full.
        do_reset();
        lat = 1; dec_ready = 1'b0;
        step(); step(); step();
        chk("half_full_dv", obs_dv, 1'b1);
        do_reset();
        dec_ready = 1'b1;
        step();
        chk("post_rst_req_hs", obs_req_hs, 1'b1);
        chk("post_rst_req_addr", obs_addr, 64'h2000);

        // Randomized traffic against the model.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            lat = $urandom_range(1, 4);
            repeat (250) begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
                dec_ready     = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 29) == 0) halt = !halt;
                redirect = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    redirect_pc = {$urandom, $urandom};
                step();
                redirect = 1'b0;
            end
        end
        halt = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
